// File: rtl/cp0_exc_pkg.sv
// Shared constants for the commit-stage exception/ERET controller:
// ExcCodes, exc vector bit positions, FSM state encodings and the entry PC.
package cp0_exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EB_PC_ADDR = 7;
  localparam int EB_RI      = 6;
  localparam int EB_OV      = 5;
  localparam int EB_SYS     = 4;
  localparam int EB_BRK     = 3;
  localparam int EB_ADEL    = 2;
  localparam int EB_ADES    = 1;
  localparam int EB_ERET    = 0;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [31:0] EXC_VEC_DEF = 32'hbfc00380;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Redirect handshake from the exception controller (master) to fetch (slave).
interface cp0_exc_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/cp0_exc_prio.sv
// Per-slot priority encoder: picks the highest-priority cause among the
// interrupt and the slot's exc bits and reports its ExcCode / BadVAddr source.
module cp0_exc_prio
  import cp0_exc_pkg::*;
(
  input  logic [7:0] exc,
  input  logic       int_i,
  output logic       hit,
  output logic [4:0] excode,
  output logic       badv_we,
  output logic       badv_pc,
  output logic       is_eret
);

  always_comb begin
    hit     = int_i | (|exc);
    excode  = '0;
    badv_we = 1'b0;
    badv_pc = 1'b0;
    is_eret = 1'b0;
    if (int_i) begin
      excode = EXC_INT;
    end else if (exc[EB_PC_ADDR]) begin
      excode  = EXC_ADEL;
      badv_we = 1'b1;
      badv_pc = 1'b1;
    end else if (exc[EB_RI]) begin
      excode = EXC_RI;
    end else if (exc[EB_OV]) begin
      excode = EXC_OV;
    end else if (exc[EB_SYS]) begin
      excode = EXC_SYS;
    end else if (exc[EB_BRK]) begin
      excode = EXC_BP;
    end else if (exc[EB_ADEL]) begin
      excode  = EXC_ADEL;
      badv_we = 1'b1;
    end else if (exc[EB_ADES]) begin
      excode  = EXC_ADES;
      badv_we = 1'b1;
    end else if (exc[EB_ERET]) begin
      is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET sequencer: arbitrates both commit slots, pulses the CP0 update,
// holds flush for FLUSH_CYCLES, then hands the redirect PC to fetch.
// Interrupt arbitration is compiled in only with CP0_EXC_INT_EN defined.
module cp0_exc_ctrl
  import cp0_exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VEC      = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i1,
  input  logic        valid_i2,
  input  logic [7:0]  exc_i1,
  input  logic [7:0]  exc_i2,
  input  logic [31:0] pc_i1,
  input  logic [31:0] pc_i2,
  input  logic [31:0] badaddr_i1,
  input  logic [31:0] badaddr_i2,
  input  logic        dslot_i1,
  input  logic        dslot_i2,
  input  logic        int_pending,
  input  logic [31:0] epc_i,
  output logic        cp0_we,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic        cp0_badv_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_exl_clr,
  output logic        flush,
  output logic        stall,
  cp0_exc_ctrl_if.master rd
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic        int_en;
`ifdef CP0_EXC_INT_EN
  assign int_en = int_pending;
`else
  logic unused_int;
  assign unused_int = int_pending;
  assign int_en     = 1'b0;
`endif

  // Interrupt rides on the oldest valid slot; with no valid slot it waits.
  logic int1, int2;
  assign int1 = int_en & valid_i1;
  assign int2 = int_en & ~valid_i1 & valid_i2;

  logic       hit1, hit2, bw1, bw2, bp1, bp2, er1, er2;
  logic [4:0] code1, code2;

  cp0_exc_prio u_prio1 (.exc(exc_i1), .int_i(int1), .hit(hit1), .excode(code1),
                        .badv_we(bw1), .badv_pc(bp1), .is_eret(er1));
  cp0_exc_prio u_prio2 (.exc(exc_i2), .int_i(int2), .hit(hit2), .excode(code2),
                        .badv_we(bw2), .badv_pc(bp2), .is_eret(er2));

  logic        sel1, ev;
  logic        s_bw, s_bp, s_er, s_ds;
  logic [4:0]  s_code;
  logic [31:0] s_pc, s_ba;

  assign sel1   = valid_i1 & hit1;
  assign ev     = sel1 | (valid_i2 & hit2);
  assign s_bw   = sel1 ? bw1        : bw2;
  assign s_bp   = sel1 ? bp1        : bp2;
  assign s_er   = sel1 ? er1        : er2;
  assign s_ds   = sel1 ? dslot_i1   : dslot_i2;
  assign s_code = sel1 ? code1      : code2;
  assign s_pc   = sel1 ? pc_i1      : pc_i2;
  assign s_ba   = sel1 ? badaddr_i1 : badaddr_i2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, bd_q, bd_d, bw_q, bw_d, exl_q, exl_d;
  logic        flush_q, flush_d, stall_q, stall_d, rv_q, rv_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d, bva_q, bva_d, rpc_q, rpc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    bw_d    = 1'b0;
    exl_d   = 1'b0;
    bd_d    = bd_q;
    code_d  = code_q;
    epc_d   = epc_q;
    bva_d   = bva_q;
    rpc_d   = rpc_q;
    flush_d = flush_q;
    stall_d = stall_q;
    rv_d    = rv_q;
    case (state_q)
      S_IDLE: if (ev) begin
        state_d = S_FLUSH;
        cnt_d   = CNT_INIT;
        flush_d = 1'b1;
        stall_d = 1'b1;
        if (s_er) begin
          exl_d = 1'b1;
          rpc_d = epc_i;
        end else begin
          we_d   = 1'b1;
          code_d = s_code;
          epc_d  = s_ds ? s_pc - 32'd4 : s_pc;
          bd_d   = s_ds;
          rpc_d  = EXC_VEC;
          if (s_bw) begin
            bw_d  = 1'b1;
            bva_d = s_bp ? s_pc : s_ba;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
          flush_d = 1'b0;
          rv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REDIRECT: if (rd.redirect_ready) begin
        state_d = S_IDLE;
        rv_d    = 1'b0;
        stall_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bw_q    <= 1'b0;
      exl_q   <= 1'b0;
      bd_q    <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      bva_q   <= '0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      bw_q    <= bw_d;
      exl_q   <= exl_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      bva_q   <= bva_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      rv_q    <= rv_d;
    end
  end

  assign cp0_we            = we_q;
  assign cp0_excode        = code_q;
  assign cp0_epc           = epc_q;
  assign cp0_bd            = bd_q;
  assign cp0_badv_we       = bw_q;
  assign cp0_badvaddr      = bva_q;
  assign cp0_exl_clr       = exl_q;
  assign flush             = flush_q;
  assign stall             = stall_q;
  assign rd.redirect_valid = rv_q;
  assign rd.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed scoreboard bench for cp0_exc_ctrl (FLUSH_CYCLES=2); covers the
// CP0_EXC_INT_EN variant when the macro is defined.
module tb_cp0_exc_ctrl;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'hbfc00380;

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid_i1, valid_i2, dslot_i1, dslot_i2, int_pending;
  logic [7:0]  exc_i1, exc_i2;
  logic [31:0] pc_i1, pc_i2, badaddr_i1, badaddr_i2, epc_i;
  logic        cp0_we, cp0_bd, cp0_badv_we, cp0_exl_clr, flush, stall;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_epc, cp0_badvaddr;

  cp0_exc_ctrl_if rif ();

  cp0_exc_ctrl #(.FLUSH_CYCLES(FC), .EXC_VEC(VEC)) dut (
    .clk(clk), .rst(rst),
    .valid_i1(valid_i1), .valid_i2(valid_i2),
    .exc_i1(exc_i1), .exc_i2(exc_i2),
    .pc_i1(pc_i1), .pc_i2(pc_i2),
    .badaddr_i1(badaddr_i1), .badaddr_i2(badaddr_i2),
    .dslot_i1(dslot_i1), .dslot_i2(dslot_i2),
    .int_pending(int_pending), .epc_i(epc_i),
    .cp0_we(cp0_we), .cp0_excode(cp0_excode), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
    .cp0_badv_we(cp0_badv_we), .cp0_badvaddr(cp0_badvaddr), .cp0_exl_clr(cp0_exl_clr),
    .flush(flush), .stall(stall), .rd(rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        badv;
    logic [31:0] badva;
    logic [31:0] rpc;
  } exp_t;

  exp_t sbq[$];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid_i1 = 0; valid_i2 = 0; exc_i1 = 0; exc_i2 = 0;
    dslot_i1 = 0; dslot_i2 = 0; int_pending = 0;
  endtask

  task automatic slot1(input logic [7:0] e, input logic [31:0] pc, input logic [31:0] ba, input logic ds);
    valid_i1 = 1; exc_i1 = e; pc_i1 = pc; badaddr_i1 = ba; dslot_i1 = ds;
  endtask

  task automatic slot2(input logic [7:0] e, input logic [31:0] pc, input logic [31:0] ba, input logic ds);
    valid_i2 = 1; exc_i2 = e; pc_i2 = pc; badaddr_i2 = ba; dslot_i2 = ds;
  endtask

  // Reference model of an accepted exception.
  task automatic push_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                          input logic badv, input logic [31:0] badva);
    exp_t e;
    e.eret = 0; e.code = code; e.epc = ds ? pc - 32'd4 : pc; e.bd = ds;
    e.badv = badv; e.badva = badva; e.rpc = VEC;
    sbq.push_back(e);
  endtask

  task automatic push_eret(input logic [31:0] tgt);
    exp_t e;
    e.eret = 1; e.code = 0; e.epc = 0; e.bd = 0; e.badv = 0; e.badva = 0; e.rpc = tgt;
    sbq.push_back(e);
  endtask

  // Inputs for the event are already driven; walks the whole sequence.
  task automatic run_seq(input string tag, input int hold, input bit early);
    exp_t e;
    if (early) rif.redirect_ready = 1;
    step();
    clr_in();
    if (sbq.size() == 0) begin
      ncmp++; nerr++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_we"}, 32'(cp0_we), 32'(!e.eret));
    chk({tag, "_exl"}, 32'(cp0_exl_clr), 32'(e.eret));
    chk({tag, "_bvwe"}, 32'(cp0_badv_we), 32'(e.badv));
    if (!e.eret) begin
      chk({tag, "_code"}, 32'(cp0_excode), 32'(e.code));
      chk({tag, "_epc"}, cp0_epc, e.epc);
      chk({tag, "_bd"}, 32'(cp0_bd), 32'(e.bd));
      if (e.badv) chk({tag, "_bva"}, cp0_badvaddr, e.badva);
    end
    chk({tag, "_flush1"}, 32'(flush), 32'd1);
    chk({tag, "_stall1"}, 32'(stall), 32'd1);
    for (int k = 2; k <= FC; k++) begin
      step();
      chk({tag, "_flushk"}, 32'(flush), 32'd1);
      chk({tag, "_pulse_off"}, 32'({cp0_we, cp0_exl_clr, cp0_badv_we}), 32'd0);
      chk({tag, "_rv_early"}, 32'(rif.redirect_valid), 32'd0);
    end
    step();
    chk({tag, "_flush_end"}, 32'(flush), 32'd0);
    chk({tag, "_rv"}, 32'(rif.redirect_valid), 32'd1);
    chk({tag, "_rpc"}, rif.redirect_pc, e.rpc);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_rv_hold"}, 32'(rif.redirect_valid), 32'd1);
      chk({tag, "_rpc_hold"}, rif.redirect_pc, e.rpc);
      chk({tag, "_stall_hold"}, 32'(stall), 32'd1);
    end
    rif.redirect_ready = 1;
    step();
    rif.redirect_ready = 0;
    chk({tag, "_rv_done"}, 32'(rif.redirect_valid), 32'd0);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
  endtask

  initial begin
    clr_in();
    pc_i1 = 0; pc_i2 = 0; badaddr_i1 = 0; badaddr_i2 = 0; epc_i = 0;
    rif.redirect_ready = 0;
    step(); step();
    chk("rst_we", 32'(cp0_we), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rv", 32'(rif.redirect_valid), 0);
    chk("rst_rpc", rif.redirect_pc, 0);
    chk("rst_epc", cp0_epc, 0);
    rst = 0;
    step();

    // slot1 overflow
    slot1(8'h20, 32'h80001000, 32'h0, 0);
    push_exc(5'h0c, 32'h80001000, 0, 0, 0);
    run_seq("ov", 0, 0);

    // slot2 adel behind clean slot1, delay slot
    slot1(8'h00, 32'h80002000, 32'h0, 0);
    slot2(8'h04, 32'h80002004, 32'h00000003, 1);
    push_exc(5'h04, 32'h80002004, 1, 1, 32'h00000003);
    run_seq("adel2", 1, 0);

    // slot1 sys + slot2 brk: slot2 dropped
    slot1(8'h10, 32'h80002100, 32'h0, 0);
    slot2(8'h08, 32'h80002104, 32'h0, 0);
    push_exc(5'h08, 32'h80002100, 0, 0, 0);
    run_seq("sys_brk", 0, 0);
    step();
    chk("sys_brk_no2nd", 32'(cp0_we), 0);

    // ERET, ready held low 5 cycles
    epc_i = 32'h80003000;
    slot1(8'h01, 32'h80002200, 32'h0, 0);
    push_eret(32'h80003000);
    run_seq("eret", 5, 0);

    // pc_addr in delay slot, EPC wraps below PC
    slot1(8'hc0, 32'h00000000, 32'h12345678, 1);
    push_exc(5'h04, 32'h00000000, 1, 1, 32'h00000000);
    run_seq("pcaddr", 0, 1);

    // ri beats ov; invalid slot1 with bits set is ignored -> ades in slot2
    slot1(8'h60, 32'h80005000, 32'h0, 0);
    push_exc(5'h0a, 32'h80005000, 0, 0, 0);
    run_seq("ri", 0, 0);
    slot2(8'h02, 32'h80005104, 32'h80000011, 0);
    exc_i1 = 8'h20; pc_i1 = 32'h80005100;
    push_exc(5'h05, 32'h80005104, 0, 1, 32'h80000011);
    run_seq("ades", 0, 0);

    // events arriving during flush are ignored
    slot1(8'h20, 32'h80006000, 32'h0, 0);
    push_exc(5'h0c, 32'h80006000, 0, 0, 0);
    step();
    slot1(8'h10, 32'h80006004, 32'h0, 0);
    step();
    clr_in();
    chk("busy_we", 32'(cp0_we), 0);
    step();
    chk("busy_rv", 32'(rif.redirect_valid), 1);
    void'(sbq.pop_front());
    rif.redirect_ready = 1;
    step();
    rif.redirect_ready = 0;
    chk("busy_idle", 32'(stall), 0);
    step();
    chk("busy_dropped", 32'(cp0_we), 0);

    // interrupt waits for a valid slot
    int_pending = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("int_wait_we", 32'(cp0_we), 0);
      chk("int_wait_stall", 32'(stall), 0);
    end
`ifdef CP0_EXC_INT_EN
    slot1(8'h00, 32'h80004000, 32'h0, 0);
    int_pending = 1;
    push_exc(5'h00, 32'h80004000, 0, 0, 0);
    run_seq("int", 0, 0);
`else
    slot1(8'h00, 32'h80004000, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("int_off_we", 32'(cp0_we), 0);
      chk("int_off_stall", 32'(stall), 0);
    end
    clr_in();
`endif

    // reset during REDIRECT
    slot1(8'h08, 32'h80007000, 32'h0, 0);
    step();
    clr_in();
    for (int k = 0; k < FC; k++) step();
    chk("rstmid_rv_pre", 32'(rif.redirect_valid), 1);
    rst = 1;
    step();
    chk("rstmid_rv", 32'(rif.redirect_valid), 0);
    chk("rstmid_rpc", rif.redirect_pc, 0);
    chk("rstmid_stall", 32'(stall), 0);
    chk("rstmid_flush", 32'(flush), 0);
    chk("rstmid_code", 32'(cp0_excode), 0);
    chk("rstmid_epc", cp0_epc, 0);
    rst = 0;
    step();
    chk("rstmid_after", 32'(rif.redirect_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Exception/ERET sequencing controller for the dual-issue commit stage. It arbitrates exception and ERET events from both commit slots. It issues a single one-cycle update command to CP0 and holds the pipeline flush for a fixed window. It then delivers the redirect PC to fetch over a valid/ready handshake. It sits between the MEM/WB commit slots, the CP0 register file and the IF stage.

## Interface
- FLUSH_CYCLES, 2: flush window length in cycles; legal range 1..15.
- EXC_VEC, 32'hbfc00380: exception entry PC.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_i1 / valid_i2  in  1  commit slot holds a real instruction
- exc_i1 / exc_i2  in  8  {pc_addr, ri, ov, sys, brk, adel, ades, eret}; bit 7..0
- pc_i1 / pc_i2  in  32  slot PC
- badaddr_i1 / badaddr_i2  in  32  data address for AdEL/AdES
- dslot_i1 / dslot_i2  in  1  slot instruction is in a delay slot
- int_pending  in  1  CP0 interrupt request (Cause.IP & Status.IM, IE=1, EXL=0)
- epc_i  in  32  current CP0 EPC (ERET target)
- cp0_we  out  1  one-cycle pulse: write excode, EPC and BD, and set EXL
- cp0_excode  out  5  ExcCode
- cp0_epc  out  32  EPC value
- cp0_bd  out  1  Cause.BD value
- cp0_badv_we  out  1  one-cycle pulse: write BadVAddr
- cp0_badvaddr  out  32  BadVAddr value
- cp0_exl_clr  out  1  one-cycle pulse on ERET
- flush  out  1  kill all younger pipeline state
- stall  out  1  commit must hold; equals state != IDLE
- redirect_valid  out  1  redirect PC available
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  IF accepts redirect

## Operation
- States: IDLE, FLUSH, REDIRECT.
- IDLE: an event is an exception or ERET in a valid slot, or an interrupt.
  - Slot 1 wins if valid with any exc bit set. Otherwise slot 2 wins if valid with any bit set.
  - A slot-2 event behind a slot-1 event is dropped.
- Interrupt: attaches to slot 1 if valid, else slot 2. With neither slot valid it waits in IDLE.
- In-slot priority, highest first, with ExcCode:
  - int: 0x00
  - pc_addr: 0x04, BadVAddr = pc
  - ri: 0x0a
  - ov: 0x0c
  - sys: 0x08
  - brk: 0x09
  - adel: 0x04, BadVAddr = badaddr
  - ades: 0x05, BadVAddr = badaddr
  - eret: lowest priority
- Exception accept:
  - Pulse cp0_we.
  - cp0_epc = dslot ? pc-4 : pc (32-bit wrap); cp0_bd = dslot.
  - Pulse cp0_badv_we only for pc_addr, adel or ades.
  - Latch redirect_pc = EXC_VEC.
- ERET accept: pulse cp0_exl_clr only, with no cp0_we; latch redirect_pc = epc_i as sampled at accept.
- Accept: go to FLUSH with the counter at FLUSH_CYCLES-1. FLUSH: decrement the counter; at 0 go to REDIRECT.
- REDIRECT: hold redirect_valid and redirect_pc stable until redirect_ready; then go to IDLE.
- Events arriving outside IDLE are ignored, because the flush discards them.

## Timing
- Reset: all outputs 0, redirect_pc 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts the sequence immediately; no redirect is issued.
- All outputs are registered.
- Event sampled at edge T:
  - cp0_we, cp0_badv_we and cp0_exl_clr are high in cycle T+1 only.
  - flush is high for cycles T+1 .. T+FLUSH_CYCLES.
  - stall is high from T+1 until the handshake completes.
  - redirect_valid rises in cycle T+FLUSH_CYCLES+1.
- The handshake completes at an edge where redirect_valid & redirect_ready. redirect_valid is 0 in the next cycle.
- A new event can be accepted at the first edge after IDLE is re-entered.
- redirect_ready high before redirect_valid has no effect.
- FLUSH_CYCLES=1: flush is a single cycle and redirect_valid starts at T+2.

## Configuration
- CP0_EXC_INT_EN defined: interrupts are arbitrated as above.
- CP0_EXC_INT_EN undefined: the int_pending port exists but is ignored, and ExcCode 0x00 is never produced.

## Structure
- Package cp0_exc_pkg holds:
  - ExcCode constants
  - exc bit indices
  - the state enum
  - the EXC_VEC default
- Sub-module cp0_exc_prio: per-slot priority encoder (exc bits plus int to hit, excode, badv_sel, is_eret). It is instantiated twice.

## Test plan
- Slot1 ov, pc=0x80001000, dslot=0, FLUSH_CYCLES=2 -> T+1: cp0_we=1, excode 0x0c, epc 0x80001000, bd 0; flush T+1..T+2; redirect 0xbfc00380 at T+3.
- Slot2 adel, badaddr=0x00000003, dslot=1, pc=0x80002004; slot1 valid and clean -> excode 0x04, epc 0x80002000, bd 1, badv_we=1, badvaddr 0x00000003.
- Slot1 sys + slot2 brk in the same cycle -> excode 0x08 only; no second cp0_we.
- ERET with epc_i=0x80003000 and redirect_ready held low for 5 cycles -> cp0_exl_clr pulse, cp0_we=0; redirect_valid and redirect_pc stable until ready; then IDLE.
- int_pending with both slots invalid for 3 cycles, then slot1 valid pc=0x80004000 (macro on) -> no action until slot valid; excode 0x00, epc 0x80004000. Macro off -> no action at all.
- rst asserted during REDIRECT -> next cycle all outputs 0, state IDLE.
